// File: rtl/regfile_ctrl.sv
// Register-file write arbiter with a post-reset clear sweep, a pending-register
// scoreboard for long-latency results and a decode-stage read stall.
module regfile_ctrl #(
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  output logic        init_done_o,
  input  logic        a_v_i,
  input  logic [4:0]  a_addr_i,
  input  logic [31:0] a_data_i,
  output logic        a_ready_o,
  input  logic        b_v_i,
  input  logic [4:0]  b_addr_i,
  input  logic [31:0] b_data_i,
  output logic        b_ready_o,
  input  logic        sb_set_v_i,
  input  logic [4:0]  sb_set_addr_i,
  input  logic        rd_v_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic        stall_o,
  output logic        rf_rv_o,
  output logic        rf_wv_o,
  output logic [4:0]  rf_ws_o,
  output logic [31:0] rf_wd_o,
  output logic [31:0] pending_o
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic {INIT, RUN} state_t;

  state_t         state_reg, state_next;
  logic [4:0]     cnt_reg;
  logic           init_done_reg;
  logic [SW-1:0]  starve_reg, starve_next;
  logic [31:0]    pending_reg, pending_next;

  logic           run;
  logic           force_b;
  logic           xfer_a, xfer_b;

  assign run     = (state_reg == RUN);
  assign force_b = run && b_v_i && (starve_reg == STARVE_LIM);
  assign xfer_a  = a_v_i && a_ready_o;
  assign xfer_b  = b_v_i && b_ready_o;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == INIT && cnt_reg == 5'd31) begin
      state_next = RUN;
    end
  end

  always_comb begin
    a_ready_o = 1'b0;
    b_ready_o = 1'b0;
    rf_wv_o   = 1'b0;
    rf_ws_o   = 5'd0;
    rf_wd_o   = 32'd0;
    rf_rv_o   = 1'b0;
    stall_o   = rd_v_i;
    if (state_reg == INIT) begin
      // State is already INIT while reset is held, so gate the sweep write on it
      rf_wv_o = reset;
      rf_ws_o = reset ? cnt_reg : 5'd0;
    end else begin
      if (force_b) begin
        b_ready_o = 1'b1;
      end else if (a_v_i) begin
        a_ready_o = 1'b1;
      end else if (b_v_i) begin
        b_ready_o = 1'b1;
      end
      if (xfer_a && a_addr_i != 5'd0) begin
        rf_wv_o = 1'b1;
        rf_ws_o = a_addr_i;
        rf_wd_o = a_data_i;
      end else if (xfer_b && b_addr_i != 5'd0) begin
        rf_wv_o = 1'b1;
        rf_ws_o = b_addr_i;
        rf_wd_o = b_data_i;
      end
      stall_o = rd_v_i && ((rs1_i != 5'd0 && pending_reg[rs1_i]) ||
                           (rs2_i != 5'd0 && pending_reg[rs2_i]));
      rf_rv_o = rd_v_i && !stall_o;
    end
  end

  always_comb begin
    starve_next = '0;
    if (run && b_v_i && !b_ready_o) begin
      starve_next = (starve_reg == STARVE_LIM) ? starve_reg : starve_reg + 1'b1;
    end
  end

  // Clear is applied before set so a same-cycle issue to that register wins
  always_comb begin
    pending_next = pending_reg;
    if (run) begin
      if (xfer_b) begin
        pending_next[b_addr_i] = 1'b0;
      end
      if (sb_set_v_i && sb_set_addr_i != 5'd0) begin
        pending_next[sb_set_addr_i] = 1'b1;
      end
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg       <= 5'd1;
      init_done_reg <= 1'b0;
      starve_reg    <= '0;
      pending_reg   <= '0;
    end else begin
      if (state_reg == INIT) begin
        cnt_reg <= cnt_reg + 5'd1;
        if (cnt_reg == 5'd31) begin
          init_done_reg <= 1'b1;
        end
      end
      starve_reg  <= starve_next;
      pending_reg <= pending_next;
    end
  end

  assign init_done_o = init_done_reg;
  assign pending_o   = pending_reg;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl: sweep, arbitration, scoreboard, stall and reset.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_done_o;
  logic        a_v_i, b_v_i, sb_set_v_i, rd_v_i;
  logic [4:0]  a_addr_i, b_addr_i, sb_set_addr_i, rs1_i, rs2_i;
  logic [31:0] a_data_i, b_data_i;
  logic        a_ready_o, b_ready_o, stall_o, rf_rv_o, rf_wv_o;
  logic [4:0]  rf_ws_o;
  logic [31:0] rf_wd_o, pending_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_ctrl #(.STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset), .init_done_o(init_done_o),
    .a_v_i(a_v_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
    .b_v_i(b_v_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
    .sb_set_v_i(sb_set_v_i), .sb_set_addr_i(sb_set_addr_i),
    .rd_v_i(rd_v_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .stall_o(stall_o), .rf_rv_o(rf_rv_o),
    .rf_wv_o(rf_wv_o), .rf_ws_o(rf_ws_o), .rf_wd_o(rf_wd_o),
    .pending_o(pending_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_v_i = 0; b_v_i = 0; sb_set_v_i = 0; rd_v_i = 0;
    a_addr_i = 0; b_addr_i = 0; sb_set_addr_i = 0; rs1_i = 0; rs2_i = 0;
    a_data_i = 0; b_data_i = 0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    rd_v_i = 1; a_v_i = 1; a_addr_i = 4;
    #3;
    chk("rst_stall", stall_o, 1);
    chk("rst_wv", rf_wv_o, 0);
    chk("rst_aready", a_ready_o, 0);
    chk("rst_done", init_done_o, 0);
    chk("rst_pend", pending_o, 0);

    // Sweep with every request active: all must be held off, scoreboard untouched
    @(posedge clk); #1;
    reset = 1'b1;
    a_v_i = 1; b_v_i = 1; b_addr_i = 6; sb_set_v_i = 1; sb_set_addr_i = 3; rd_v_i = 1;
    for (int i = 1; i <= 31; i++) begin
      #1;
      chk("sweep_wv", rf_wv_o, 1);
      chk("sweep_ws", rf_ws_o, i);
      chk("sweep_wd", rf_wd_o, 0);
      chk("sweep_rdy", {a_ready_o, b_ready_o, rf_rv_o, stall_o}, 4'b0001);
      chk("sweep_done", init_done_o, 0);
      tick();
    end
    idle();
    #1;
    chk("run_done", init_done_o, 1);
    chk("run_idle_wv", {rf_wv_o, a_ready_o, b_ready_o}, 0);
    chk("run_idle_wsd", {rf_ws_o, rf_wd_o}, 0);
    chk("init_sb_ign", pending_o, 0);

    // Fixed priority with starvation relief: A,A,A,B,A,A,A,B
    a_v_i = 1; a_addr_i = 1; a_data_i = 32'h11;
    b_v_i = 1; b_addr_i = 2; b_data_i = 32'h22;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("arb_a", a_ready_o, (i % 4 == 3) ? 0 : 1);
      chk("arb_b", b_ready_o, (i % 4 == 3) ? 1 : 0);
      chk("arb_ws", rf_ws_o, (i % 4 == 3) ? 2 : 1);
      chk("arb_wd", rf_wd_o, (i % 4 == 3) ? 32'h22 : 32'h11);
      tick();
    end
    // Two denials, then B drops: counter must clear so the next three go to A
    tick(); tick();
    b_v_i = 0; #1;
    chk("arb_bdrop", a_ready_o, 1);
    tick();
    b_v_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("arb_clr_b", b_ready_o, (i == 3) ? 1 : 0);
      tick();
    end
    idle();
    #1;
    chk("arb_none", {a_ready_o, b_ready_o, rf_wv_o}, 0);

    // Pending x5 stalls reads until B writes it back
    sb_set_v_i = 1; sb_set_addr_i = 5;
    tick();
    idle();
    rd_v_i = 1; rs1_i = 5;
    #1;
    chk("sb5_pend", pending_o, 32'h20);
    chk("sb5_stall", stall_o, 1);
    chk("sb5_rv", rf_rv_o, 0);
    b_v_i = 1; b_addr_i = 5; b_data_i = 32'h55;
    #1;
    chk("sb5_bgrant", b_ready_o, 1);
    chk("sb5_bws", rf_ws_o, 5);
    chk("sb5_same_cyc", stall_o, 1);
    tick();
    b_v_i = 0; #1;
    chk("sb5_unstall", stall_o, 0);
    chk("sb5_rv1", rf_rv_o, 1);
    chk("sb5_clear", pending_o, 0);

    // Set and B-clear of x7 together: set wins
    idle();
    sb_set_v_i = 1; sb_set_addr_i = 7; b_v_i = 1; b_addr_i = 7;
    tick();
    idle();
    rd_v_i = 1; rs2_i = 7; #1;
    chk("sb7_pend", pending_o, 32'h80);
    chk("sb7_rs2_stall", stall_o, 1);
    sb_set_v_i = 1; sb_set_addr_i = 7;
    tick();
    sb_set_addr_i = 9;
    #1;
    chk("sb7_reset_idem", pending_o, 32'h80);
    tick();
    idle();
    a_v_i = 1; a_addr_i = 9; a_data_i = 32'h12345678;
    #1;
    chk("a9_pend", pending_o, 32'h280);
    chk("a9_ws", rf_ws_o, 9);
    chk("a9_wd", rf_wd_o, 32'h12345678);
    tick();
    a_addr_i = 0; a_data_i = 32'hDEADBEEF; sb_set_v_i = 1; sb_set_addr_i = 0;
    #1;
    chk("a9_nomod", pending_o, 32'h280);
    chk("a0_ready", a_ready_o, 1);
    chk("a0_wv", rf_wv_o, 0);
    tick();
    idle();
    #1;
    chk("sb0_ign", pending_o, 32'h280);

    // Reset in RUN with scoreboard state present
    rd_v_i = 1; a_v_i = 1; a_addr_i = 3;
    reset = 1'b0; #1;
    chk("rrun_pend", pending_o, 0);
    chk("rrun_done", init_done_o, 0);
    chk("rrun_outs", {a_ready_o, b_ready_o, rf_wv_o, rf_rv_o, stall_o}, 5'b00001);
    tick();
    idle();
    reset = 1'b1;
    for (int i = 1; i <= 11; i++) tick();
    #1;
    chk("mid_ws12", rf_ws_o, 12);
    reset = 1'b0; #1;
    chk("mid_rst_wv", rf_wv_o, 0);
    chk("mid_rst_ws", rf_ws_o, 0);
    tick();
    reset = 1'b1; #1;
    chk("restart_ws", rf_ws_o, 1);
    chk("restart_wv", rf_wv_o, 1);
    for (int i = 1; i <= 31; i++) tick();
    #1;
    chk("restart_done", init_done_o, 1);
    chk("restart_idle", rf_wv_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3: consecutive cycles requester B may be denied before it is forced a grant.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port init_done_o  output  1  high once the post-reset register-clear sweep has finished.
REQ-005 SHALL have ports a_v_i / a_addr_i / a_data_i  input  1/5/32  requester A (pipeline writeback) write request.
REQ-006 SHALL have port a_ready_o  output  1  grant to A; a write transfers when a_v_i && a_ready_o.
REQ-007 SHALL have ports b_v_i / b_addr_i / b_data_i  input  1/5/32  requester B (long-latency unit) write request.
REQ-008 SHALL have port b_ready_o  output  1  grant to B; a write transfers when b_v_i && b_ready_o.
REQ-009 SHALL have ports sb_set_v_i / sb_set_addr_i  input  1/5  marks a destination register pending when a long-latency op issues.
REQ-010 SHALL have ports rd_v_i / rs1_i / rs2_i  input  1/5/5  decode-stage read request.
REQ-011 SHALL have port stall_o  output  1  read must not proceed this cycle.
REQ-012 SHALL have port rf_rv_o  output  1  register-file read enable.
REQ-013 SHALL have ports rf_wv_o / rf_ws_o / rf_wd_o  output  1/5/32  register-file write port.
REQ-014 SHALL have port pending_o  output  32  scoreboard bit vector; bit 0 is always 0.

Function
REQ-015 SHALL implement FSM states INIT and RUN; reset forces INIT.
REQ-016 In INIT, a 5-bit counter SHALL start at 1; each cycle rf_wv_o=1, rf_ws_o=counter, rf_wd_o=0; counter increments.
REQ-017 After the cycle writing address 31 (31 cycles), the FSM SHALL enter RUN; init_done_o SHALL rise on that same edge and stay high until reset.
REQ-018 In INIT: a_ready_o=0, b_ready_o=0, rf_rv_o=0, stall_o=rd_v_i; sb_set_v_i SHALL be ignored.
REQ-019 In RUN, arbitration SHALL be fixed-priority A over B, unless the starve counter equals STARVE_MAX, in which case B SHALL be granted and A denied.
REQ-020 Starve counter SHALL increment (saturating at STARVE_MAX) each cycle b_v_i=1 and B is not granted; it SHALL clear when B is granted or b_v_i=0.
REQ-021 Grants SHALL be combinational from the current-cycle valids and the counter; at most one of a_ready_o, b_ready_o SHALL be high per cycle; with no valid, both SHALL be 0.
REQ-022 On a transfer to a nonzero address: rf_wv_o=1, rf_ws_o/rf_wd_o = the winner's addr/data in the same cycle.
REQ-023 A transfer to address 0 SHALL complete (ready high) with rf_wv_o=0.
REQ-024 With no transfer in RUN: rf_wv_o=0, rf_ws_o=0, rf_wd_o=0.
REQ-025 In RUN, sb_set_v_i with nonzero sb_set_addr_i SHALL set pending[addr] at the next edge; address 0 SHALL be ignored.
REQ-026 A B transfer SHALL clear pending[b_addr_i] at the next edge.
REQ-027 An A transfer SHALL NOT modify pending.
REQ-028 Simultaneous set and B-clear of the same address SHALL leave the bit set.
REQ-029 Setting an already-pending bit SHALL leave it set; there is no counting.
REQ-030 stall_o SHALL be combinational in RUN: rd_v_i && ((rs1_i!=0 && pending[rs1_i]) || (rs2_i!=0 && pending[rs2_i])).
REQ-031 stall_o SHALL use the registered pending vector; a same-cycle B clear SHALL NOT suppress the stall.
REQ-032 rf_rv_o SHALL equal rd_v_i && !stall_o in RUN.

Reset
REQ-033 Asserting reset (low) at any time, including mid-sweep or mid-arbitration, SHALL asynchronously set: FSM=INIT, counter=1, starve counter=0, pending=0, init_done_o=0.
REQ-034 While reset is low: all outputs 0, except stall_o=rd_v_i.
REQ-035 The sweep SHALL begin on the first posedge after deassertion.

Verification
REQ-036 Release reset -> rf_wv_o=1 for exactly 31 cycles, addresses 1..31, data 0; init_done_o rises after address 31.
REQ-037 RUN, a_v_i=b_v_i=1 held, STARVE_MAX=3 -> grant pattern A,A,A,B,A,A,A,B.
REQ-038 sb_set x5; next cycle rd_v_i=1, rs1_i=5 -> stall_o=1, rf_rv_o=0; B writes x5 -> stall_o=0 one cycle later.
REQ-039 sb_set x7 and B write x7 in the same cycle -> pending[7]=1 afterwards.
REQ-040 A writes addr 0 with data 0xDEADBEEF -> a_ready_o=1, rf_wv_o=0; pending_o[0]=0 after sb_set addr 0.
REQ-041 Reset asserted at sweep address 12 -> outputs 0 immediately; sweep restarts at address 1 after release.
